// File: rtl/gate_pulse_conditioner_if.sv
// gate_pulse_conditioner_if
// Bundles the gate conditioner's data/strobe signals.
//   en          : gate generator enable (clk-synchronous)
//   cmp_raw     : asynchronous comparator pulse, rising edge = event
//   cmp_pulse   : one-cycle strobe per captured cmp_raw event
//   set         : one-cycle gate strobe
//   last_count  : pulse count of the most recently closed window
//   count_vld   : one-cycle strobe when last_count updates
//   count_ovf   : most recently closed window saturated
// master = stimulus side, slave = conditioner side.
// PCNT_W must match the conditioner's PCNT_W.
interface gate_pulse_conditioner_if #(
   parameter int PCNT_W = 8
);
   logic              en;
   logic              cmp_raw;
   logic              cmp_pulse;
   logic              set;
   logic [PCNT_W-1:0] last_count;
   logic              count_vld;
   logic              count_ovf;

   modport master (
      output en, cmp_raw,
      input  cmp_pulse, set, last_count, count_vld, count_ovf
   );

   modport slave (
      input  en, cmp_raw,
      output cmp_pulse, set, last_count, count_vld, count_ovf
   );
endinterface

// File: rtl/gate_pulse_conditioner.sv
// gate_pulse_conditioner
// Captures narrow asynchronous comparator pulses into single-cycle clk
// strobes, generates the periodic gate strobe, and reports the number of
// captured pulses per completed gate window.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of gate_pulse_conditioner_if (en, cmp_raw in;
//           cmp_pulse, set, last_count, count_vld, count_ovf out)
// All outputs are registered.
module gate_pulse_conditioner #(
   parameter int GATE_CYCLES = 1000,
   parameter int GCNT_W      = 10,
   parameter int PCNT_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   gate_pulse_conditioner_if.slave   bus
);

   localparam logic [GCNT_W-1:0] G_LAST  = GCNT_W'(GATE_CYCLES - 1);
   localparam logic [PCNT_W-1:0] ACC_MAX = '1;

   // ---------------------------------------------------------------
   // Capture: the pulse is far narrower than a clk period, so it is
   // turned into a level change that the clk domain can sample safely.
   // ---------------------------------------------------------------
   logic tog;

   always_ff @(posedge bus.cmp_raw or negedge rst_n) begin
      if (!rst_n) tog <= 1'b0;
      else        tog <= ~tog;
   end

   logic [SYNC_STAGES-1:0] sync;
   logic                   hist;
   logic                   cmp_pulse_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync        <= '0;
         hist        <= 1'b0;
         cmp_pulse_r <= 1'b0;
      end else begin
         sync        <= {sync[SYNC_STAGES-2:0], tog};
         hist        <= sync[SYNC_STAGES-1];
         // any toggle transition is one event
         cmp_pulse_r <= sync[SYNC_STAGES-1] ^ hist;
      end
   end

   // ---------------------------------------------------------------
   // Gate generator and per-window accumulator
   // ---------------------------------------------------------------
   logic [GCNT_W-1:0] g;
   logic [PCNT_W-1:0] acc;
   logic              ovf;
   logic              set_r;
   logic              count_vld_r;
   logic              count_ovf_r;
   logic [PCNT_W-1:0] last_count_r;
   logic              close;
   logic              sat_hit;

   assign close   = (g == G_LAST);
   // a pulse arriving while already saturated is a lost count
   assign sat_hit = cmp_pulse_r && (acc == ACC_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g            <= '0;
         acc          <= '0;
         ovf          <= 1'b0;
         set_r        <= 1'b0;
         count_vld_r  <= 1'b0;
         count_ovf_r  <= 1'b0;
         last_count_r <= '0;
      end else if (!bus.en) begin
         // disabled: window in progress is dropped, results untouched
         g           <= '0;
         acc         <= '0;
         ovf         <= 1'b0;
         set_r       <= 1'b0;
         count_vld_r <= 1'b0;
      end else begin
         set_r       <= close;
         count_vld_r <= close;
         if (close) begin
            g            <= '0;
            // the pulse sampled on the closing edge still belongs here
            last_count_r <= (cmp_pulse_r && !sat_hit) ? acc + 1'b1 : acc;
            count_ovf_r  <= ovf | sat_hit;
            acc          <= '0;
            ovf          <= 1'b0;
         end else begin
            g <= g + 1'b1;
            if (cmp_pulse_r) begin
               if (sat_hit) ovf <= 1'b1;
               else         acc <= acc + 1'b1;
            end
         end
      end
   end

   assign bus.cmp_pulse  = cmp_pulse_r;
   assign bus.set        = set_r;
   assign bus.count_vld  = count_vld_r;
   assign bus.count_ovf  = count_ovf_r;
   assign bus.last_count = last_count_r;

endmodule

// File: tb/tb_gate_pulse_conditioner.sv
// tb_gate_pulse_conditioner
// Drives directed and randomized comparator events, enable and reset
// activity. Stimulus pushes expected strobe edges into queues; a negedge
// monitor pops and compares every output each cycle.
`timescale 1ns/1ps
module tb_gate_pulse_conditioner;

   localparam int GATE = 1000;
   localparam int GW   = 10;
   localparam int PW   = 8;
   localparam int SYNC = 2;
   localparam int PMAX = (1 << PW) - 1;

   logic clk;
   logic rst_n;

   gate_pulse_conditioner_if #(.PCNT_W(PW)) bus ();

   gate_pulse_conditioner #(
      .GATE_CYCLES(GATE), .GCNT_W(GW), .PCNT_W(PW), .SYNC_STAGES(SYNC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #500 clk = ~clk;

   int ecount = 0;              // index of the most recent rising edge
   always @(posedge clk) ecount++;

   int n_pass  = 0;
   int n_total = 0;

   int pulse_q[$];              // edges after which cmp_pulse must be high
   int all_p[$];                // every predicted pulse edge, for window counts
   int set_q[$];                // edges after which set must be high
   int run_s = -1;              // first edge sampling en high, -1 when idle
   int exp_last = 0;
   int exp_ovf  = 0;

   task automatic check(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, ecount, act, exp);
   endtask

   // A window closing at edge c counts pulses visible after edges c-GATE..c-1.
   function automatic int win_count(input int c);
      int n = 0;
      foreach (all_p[i]) if (all_p[i] >= c - GATE && all_p[i] <= c - 1) n++;
      return n;
   endfunction

   function automatic int next_close(input int after);
      int base = run_s + GATE - 1;
      if (after < base) return base;
      return base + ((after - base) / GATE + 1) * GATE;
   endfunction

   task automatic tick();
      @(posedge clk);
      #100;
      if (run_s >= 0 && ecount >= run_s && ((ecount - run_s + 1) % GATE) == 0)
         set_q.push_back(ecount);
   endtask

   task automatic wait_until(input int e);
      while (ecount < e) tick();
   endtask

   task automatic raw_pulse();
      bus.cmp_raw = 1'b1;
      pulse_q.push_back(ecount + SYNC + 1);
      all_p.push_back(ecount + SYNC + 1);
      #8;
      bus.cmp_raw = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_cmp_pulse"},  int'(bus.cmp_pulse), 0);
      check({tag, "_set"},        int'(bus.set), 0);
      check({tag, "_count_vld"},  int'(bus.count_vld), 0);
      check({tag, "_count_ovf"},  int'(bus.count_ovf), 0);
      check({tag, "_last_count"}, int'(bus.last_count), 0);
   endtask

   // Monitor: one comparison per output per cycle.
   always @(negedge clk) begin
      bit es, ep;
      int n;
      es = (set_q.size() > 0) && (set_q[0] == ecount);
      if (es) begin
         void'(set_q.pop_front());
         n        = win_count(ecount);
         exp_last = (n > PMAX) ? PMAX : n;
         exp_ovf  = (n > PMAX) ? 1 : 0;
      end
      ep = (pulse_q.size() > 0) && (pulse_q[0] == ecount);
      if (ep) void'(pulse_q.pop_front());
      check("set",        int'(bus.set), int'(es));
      check("count_vld",  int'(bus.count_vld), int'(es));
      check("last_count", int'(bus.last_count), exp_last);
      check("count_ovf",  int'(bus.count_ovf), exp_ovf);
      check("cmp_pulse",  int'(bus.cmp_pulse), int'(ep));
   end

   initial begin
      #50_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, c2, c3, stop_at;
      rst_n       = 1'b0;
      bus.en      = 1'b1;
      bus.cmp_raw = 1'b0;
      #1;
      check_zero("reset");
      repeat (3) tick();
      rst_n = 1'b1;
      run_s = ecount + 1;

      // one pulse in each of the first windows
      c = run_s;
      wait_until(c + 110);  raw_pulse();
      wait_until(c + 1390); raw_pulse();
      wait_until(c + 2499); raw_pulse();
      wait_until(c + 3700); raw_pulse();

      // pulse on the cycle before set, then on the set cycle itself
      c = next_close(ecount + 4);
      wait_until(c - 4); raw_pulse();
      c2 = c + GATE;
      wait_until(c2 - 3); raw_pulse();
      wait_until(c2 + GATE + 1);

      // saturation: 300 events 3 cycles apart, then an empty window
      c3 = next_close(ecount);
      wait_until(c3);
      for (int i = 0; i < 300; i++) begin
         raw_pulse();
         tick(); tick(); tick();
      end
      wait_until(c3 + GATE - 1 + GATE + 1);

      // random event spacing across several windows
      stop_at = ecount + 4 * GATE;
      while (ecount < stop_at) begin
         repeat ($urandom_range(5, 40)) tick();
         raw_pulse();
      end
      repeat (10) tick();

      // enable dropped mid-window, raised 10 cycles later
      c = next_close(ecount);
      wait_until(c + 200); raw_pulse();
      wait_until(c + 500);
      bus.en = 1'b0;
      run_s  = -1;
      repeat (10) tick();
      bus.en = 1'b1;
      run_s  = ecount + 1;
      c = run_s;
      wait_until(c + 50); raw_pulse();
      wait_until(c + GATE + 400);

      // asynchronous reset between clock edges, mid-window
      #200;
      rst_n = 1'b0;
      run_s = -1;
      set_q.delete();
      exp_last = 0;
      exp_ovf  = 0;
      #1;
      check_zero("async_reset");
      tick(); tick();
      rst_n = 1'b1;
      run_s = ecount + 1;
      c = run_s;
      wait_until(c + 110); raw_pulse();
      wait_until(c + 3 * GATE + 2);

      repeat (10) tick();
      check("pulse_q_drained", pulse_q.size(), 0);
      check("set_q_drained",   set_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
